pcspma_link_monitor: RTL and testbench
======================================

// Module: pcspma_link_monitor
// PURPOSE
//  Consumes the 16-bit PCS/PMA status vector of the SGMII core and drives the core's speed_is_10_100 /
//  speed_is_100 inputs, plus link_up, speed and duplex for fpga_core and the LEDs. Qualifies the link
//  over a stable window, counts link drops, and pulses an_restart if autonegotiation stalls.
//  Sits between the PCS/PMA status output and its speed and an_restart_config inputs, in the 125 MHz domain.
// PARAMETERS
//  STABLE_CYCLES      125000     cycles link must stay good before link_up (1 ms @125 MHz); >=2
//  AN_TIMEOUT_CYCLES  125000000  cycles in DOWN with sync but no link before an_restart; >=2
//  CNT_WIDTH          16         width of link_drop_count
// PORTS
//  clk              in   1          125 MHz clock
//  rst              in   1          asynchronous reset, active-high
//  status_vector    in   16         PCS/PMA status: [0] link, [1] sync, [11:10] speed, [12] duplex
//  count_clear      in   1          synchronous clear of link_drop_count
//  link_up          out  1          qualified link indication
//  speed            out  2          latched speed code: 00 10M, 01 100M, 10 1G
//  duplex           out  1          latched duplex, 1 = full
//  speed_is_10_100  out  1          speed != 2'b10
//  speed_is_100     out  1          speed == 2'b01
//  an_restart       out  1          one-cycle autonegotiation restart pulse
//  link_drop_count  out  CNT_WIDTH  saturating count of UP->DOWN transitions
//  irq, irq_ack     out/in 1        present only with LINK_MONITOR_IRQ_EN
// BEHAVIOUR
//  - status_vector passes through a 2-flop synchroniser (rst clears it to 0); all logic uses the synced copy (s_*).
//  - good = s_link & s_sync & (s_speed != 2'b11). Speed 2'b11 is reserved and never qualifies.
//  - Reset values: state DOWN, link_up 0, speed 2'b10, duplex 1, speed_is_10_100 0, speed_is_100 0,
//    an_restart 0, link_drop_count 0, both timers 0, irq 0.
//  - FSM states: DOWN, QUALIFY, UP, RESTART.
//  - DOWN:
//    - good -> QUALIFY with qual_cnt=0 and cand_speed/cand_duplex captured.
//    - Otherwise, while s_sync=1 and s_link=0, an_cnt increments; an_cnt clears when that condition is false.
//    - an_cnt == AN_TIMEOUT_CYCLES-1 -> RESTART.
//  - QUALIFY:
//    - !good -> DOWN.
//    - s_speed or s_duplex differs from the candidate: recapture the candidate, qual_cnt=0, stay.
//    - qual_cnt == STABLE_CYCLES-1 -> UP: latch speed/duplex from the candidate; link_up=1 from the next cycle.
//    - Otherwise qual_cnt++.
//    - Latency: status valid at input -> link_up high after exactly STABLE_CYCLES+3 clk edges.
//  - UP:
//    - !good -> DOWN, link_up=0 next cycle, link_drop_count++ (saturates at all-ones).
//    - Speed change while good -> DOWN and counts as a drop; speed/duplex keep their last latched values.
//  - RESTART: an_restart=1 for exactly this one cycle, an_cnt=0, then DOWN unconditionally.
//  - speed_is_10_100 / speed_is_100 are registered decodes of latched speed, updated on the UP entry edge only.
//  - count_clear together with an increment: clear first, then increment; result is 1.
//  - rst mid-operation returns every output to its reset value immediately (asynchronously).
// CONFIGURATION
//  LINK_MONITOR_IRQ_EN defined:
//    - Adds output irq and input irq_ack.
//    - irq sets on every UP entry and every UP->DOWN exit; it clears on irq_ack.
//    - Set wins over a simultaneous ack.
//  LINK_MONITOR_IRQ_EN undefined: irq and irq_ack ports are absent; all other behaviour is identical.
// TESTING  (STABLE_CYCLES=8, AN_TIMEOUT_CYCLES=32, CNT_WIDTH=4)
//  - status=16'h1803 (1G full, link, sync) held from cycle 0 -> link_up=1 at edge 11;
//    speed=10, speed_is_10_100=0, speed_is_100=0.
//  - status=16'h1403 (100M full) held -> after qualification speed=01, speed_is_10_100=1, speed_is_100=1.
//  - link up, then clear bit0 for 1 cycle -> link_up=0, link_drop_count=1; requalifies after 8+ cycles.
//  - Change speed bits 10 -> 01 at qual_cnt=5 while link/sync held -> qualification restarts;
//    link_up rises 8 cycles after the change is synced.
//  - status=16'h0002 (sync, no link) held -> an_restart single pulse at cycle 35, then every 33 cycles.
//  - 20 drops with count_clear=0 -> count saturates at 15.
//  - count_clear coincident with a drop -> count=1.
//  - IRQ_EN: link up -> irq=1; irq_ack in the same cycle as the next drop -> irq stays 1.
//  - Assert rst while in QUALIFY -> all outputs at reset values in the same cycle; normal qualification after release.

Source files
------------

// File: rtl/pcspma_link_monitor.sv
// ---------------------------------------------------------------------------
// PcspmaLinkMonitor (module pcspma_link_monitor)
//
// Watches the 16-bit PCS/PMA status vector of the SGMII core and turns it
// into a qualified link indication for fpga_core and the LEDs. It also drives
// the speed select inputs of the core, counts link drops and requests an
// autonegotiation restart if the core has sync but never gets link.
// Runs entirely in the 125 MHz clock domain.
//
// Ports
//   clk              in   125 MHz clock
//   rst              in   asynchronous reset, active-high
//   status_vector    in   [0] link, [1] sync, [11:10] speed, [12] duplex
//   count_clear      in   synchronous clear of link_drop_count
//   irq              out  link change interrupt   (LINK_MONITOR_IRQ_EN only)
//   irq_ack          in   interrupt acknowledge   (LINK_MONITOR_IRQ_EN only)
//   link_up          out  qualified link indication
//   speed            out  latched speed code: 00 10M, 01 100M, 10 1G
//   duplex           out  latched duplex, 1 = full
//   speed_is_10_100  out  registered decode: speed != 2'b10
//   speed_is_100     out  registered decode: speed == 2'b01
//   an_restart       out  one-cycle autonegotiation restart pulse
//   link_drop_count  out  saturating count of UP->DOWN transitions
//
// Build option: define LINK_MONITOR_IRQ_EN to add the irq/irq_ack pair.
// ---------------------------------------------------------------------------
module pcspma_link_monitor #(
  parameter int unsigned STABLE_CYCLES     = 125000,
  parameter int unsigned AN_TIMEOUT_CYCLES = 125000000,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          status_vector,
  input  logic                 count_clear,
`ifdef LINK_MONITOR_IRQ_EN
  output logic                 irq,
  input  logic                 irq_ack,
`endif
  output logic                 link_up,
  output logic [1:0]           speed,
  output logic                 duplex,
  output logic                 speed_is_10_100,
  output logic                 speed_is_100,
  output logic                 an_restart,
  output logic [CNT_WIDTH-1:0] link_drop_count
);

  localparam int QW = $clog2(STABLE_CYCLES);
  localparam int AW = $clog2(AN_TIMEOUT_CYCLES);
  localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] AN_LAST   = AW'(AN_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {DOWN, QUALIFY, UP, RESTART} LinkState;

  LinkState             state_q, state_d;
  logic [15:0]          syncMeta_q, sync_q;
  logic [QW-1:0]        qualCnt_q, qualCnt_d;
  logic [AW-1:0]        anCnt_q, anCnt_d;
  logic [1:0]           candSpeed_q, candSpeed_d;
  logic                 candDuplex_q, candDuplex_d;
  logic                 linkUp_q, linkUp_d;
  logic [1:0]           speed_q, speed_d;
  logic                 duplex_q, duplex_d;
  logic                 speedIs10100_q, speedIs10100_d;
  logic                 speedIs100_q, speedIs100_d;
  logic [CNT_WIDTH-1:0] dropCnt_q, dropCnt_d, dropBase;
  logic                 dropInc;

  logic                 sLink, sSync, sDuplex, good;
  logic [1:0]           sSpeed;
  logic                 unusedSyncBits;

  // Synchronised copies of the status fields; only these are used below.
  assign sLink          = sync_q[0];
  assign sSync          = sync_q[1];
  assign sSpeed         = sync_q[11:10];
  assign sDuplex        = sync_q[12];
  assign good           = sLink & sSync & (sSpeed != 2'b11);
  assign unusedSyncBits = ^{sync_q[15:13], sync_q[9:2]};

  // State and output registers, including the two-flop status synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta_q     <= '0;
      sync_q         <= '0;
      state_q        <= DOWN;
      qualCnt_q      <= '0;
      anCnt_q        <= '0;
      candSpeed_q    <= 2'b10;
      candDuplex_q   <= 1'b1;
      linkUp_q       <= 1'b0;
      speed_q        <= 2'b10;
      duplex_q       <= 1'b1;
      speedIs10100_q <= 1'b0;
      speedIs100_q   <= 1'b0;
      dropCnt_q      <= '0;
    end else begin
      syncMeta_q     <= status_vector;
      sync_q         <= syncMeta_q;
      state_q        <= state_d;
      qualCnt_q      <= qualCnt_d;
      anCnt_q        <= anCnt_d;
      candSpeed_q    <= candSpeed_d;
      candDuplex_q   <= candDuplex_d;
      linkUp_q       <= linkUp_d;
      speed_q        <= speed_d;
      duplex_q       <= duplex_d;
      speedIs10100_q <= speedIs10100_d;
      speedIs100_q   <= speedIs100_d;
      dropCnt_q      <= dropCnt_d;
    end
  end

  // Link FSM: qualify a stable speed/duplex before declaring the link up,
  // and kick autonegotiation if sync is present but link never arrives.
  always_comb begin
    state_d        = state_q;
    qualCnt_d      = qualCnt_q;
    anCnt_d        = anCnt_q;
    candSpeed_d    = candSpeed_q;
    candDuplex_d   = candDuplex_q;
    linkUp_d       = linkUp_q;
    speed_d        = speed_q;
    duplex_d       = duplex_q;
    speedIs10100_d = speedIs10100_q;
    speedIs100_d   = speedIs100_q;
    dropInc        = 1'b0;

    unique case (state_q)
      DOWN: begin
        if (good) begin
          state_d      = QUALIFY;
          qualCnt_d    = '0;
          anCnt_d      = '0;
          candSpeed_d  = sSpeed;
          candDuplex_d = sDuplex;
        end else if (sSync && !sLink) begin
          if (anCnt_q == AN_LAST) begin
            state_d = RESTART;
            anCnt_d = '0;
          end else begin
            anCnt_d = anCnt_q + 1'b1;
          end
        end else begin
          anCnt_d = '0;
        end
      end
      QUALIFY: begin
        if (!good) begin
          state_d = DOWN;
        end else if ((sSpeed != candSpeed_q) || (sDuplex != candDuplex_q)) begin
          // Partner still settling: restart the window on the new values.
          candSpeed_d  = sSpeed;
          candDuplex_d = sDuplex;
          qualCnt_d    = '0;
        end else if (qualCnt_q == QUAL_LAST) begin
          state_d        = UP;
          linkUp_d       = 1'b1;
          speed_d        = candSpeed_q;
          duplex_d       = candDuplex_q;
          speedIs10100_d = (candSpeed_q != 2'b10);
          speedIs100_d   = (candSpeed_q == 2'b01);
        end else begin
          qualCnt_d = qualCnt_q + 1'b1;
        end
      end
      UP: begin
        // A speed change under a good link is treated as a drop; the latched
        // speed/duplex are kept until the next qualification completes.
        if (!good || (sSpeed != speed_q)) begin
          state_d  = DOWN;
          linkUp_d = 1'b0;
          dropInc  = 1'b1;
        end
      end
      RESTART: begin
        state_d = DOWN;
        anCnt_d = '0;
      end
      default: state_d = DOWN;
    endcase
  end

  // Drop counter: a clear in the same cycle as a drop leaves a count of one.
  always_comb begin
    dropBase  = count_clear ? '0 : dropCnt_q;
    dropCnt_d = dropBase;
    if (dropInc && (dropBase != '1)) begin
      dropCnt_d = dropBase + 1'b1;
    end
  end

`ifdef LINK_MONITOR_IRQ_EN
  logic irq_q, irq_d, upEntry;

  assign upEntry = (state_q == QUALIFY) && (state_d == UP);

  // Interrupt flag: link changes set it, software acks clear it, set wins.
  always_comb begin
    irq_d = irq_q;
    if (upEntry || dropInc) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign link_up         = linkUp_q;
  assign speed           = speed_q;
  assign duplex          = duplex_q;
  assign speed_is_10_100 = speedIs10100_q;
  assign speed_is_100    = speedIs100_q;
  assign an_restart      = (state_q == RESTART);
  assign link_drop_count = dropCnt_q;

endmodule

// File: tb/tb_pcspma_link_monitor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pcspma_link_monitor
//
// Randomised and directed stimulus against a cycle-level reference model of
// the link monitor. The model pushes the expected outputs for every clock
// into a queue; a separate monitor pops and compares one entry per clock.
// ---------------------------------------------------------------------------
module tb_pcspma_link_monitor;

  localparam int STABLE = 8;
  localparam int ANTO   = 32;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   status = 16'h0000;
  logic          countClear = 1'b0;
  logic          linkUp;
  logic [1:0]    speed;
  logic          duplex;
  logic          is10100;
  logic          is100;
  logic          anRestart;
  logic [CW-1:0] dropCount;
`ifdef LINK_MONITOR_IRQ_EN
  logic          irq;
  logic          irqAck = 1'b0;
`endif

  logic randomClear = 1'b0;
  logic randomAck   = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  pcspma_link_monitor #(
    .STABLE_CYCLES    (STABLE),
    .AN_TIMEOUT_CYCLES(ANTO),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .status_vector  (status),
    .count_clear    (countClear),
`ifdef LINK_MONITOR_IRQ_EN
    .irq            (irq),
    .irq_ack        (irqAck),
`endif
    .link_up        (linkUp),
    .speed          (speed),
    .duplex         (duplex),
    .speed_is_10_100(is10100),
    .speed_is_100   (is100),
    .an_restart     (anRestart),
    .link_drop_count(dropCount)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic          linkUp;
    logic [1:0]    speed;
    logic          duplex;
    logic          is10100;
    logic          is100;
    logic          anRestart;
    logic [CW-1:0] count;
    logic          irq;
  } Expect;

  Expect expQ[$];

  // Reference model state: a run length of consecutive good, unchanged
  // samples decides qualification; sync-without-link samples are counted
  // towards an autonegotiation restart.
  logic [15:0] mPipe1 = '0, mPipe2 = '0;
  int          mRun = 0, mAn = 0, mDrops = 0;
  logic        mUp = 0, mRestart = 0, mIrq = 0;
  logic [1:0]  mSpeed = 2'b10, mCandSpeed = 2'b10;
  logic        mDuplex = 1'b1, mCandDuplex = 1'b1;

  task automatic modelReset();
    mPipe1 = '0; mPipe2 = '0; mRun = 0; mAn = 0; mDrops = 0;
    mUp = 0; mRestart = 0; mIrq = 0;
    mSpeed = 2'b10; mDuplex = 1'b1; mCandSpeed = 2'b10; mCandDuplex = 1'b1;
  endtask

  // Model process: evaluates one clock edge using the inputs at that edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      modelReset();
    end else begin
      logic [15:0] s;
      logic        good, drop, setIrq;
      Expect       e;
      s      = mPipe2;
      good   = s[0] && s[1] && (s[11:10] != 2'b11);
      drop   = 1'b0;
      setIrq = 1'b0;
      if (mRestart) begin
        mRestart = 0; mRun = 0; mAn = 0;
      end else if (!mUp) begin
        if (good) begin
          mAn = 0;
          if (mRun > 0 && s[11:10] == mCandSpeed && s[12] == mCandDuplex) begin
            mRun++;
          end else begin
            mRun = 1; mCandSpeed = s[11:10]; mCandDuplex = s[12];
          end
          if (mRun == STABLE + 1) begin
            mUp = 1; mSpeed = mCandSpeed; mDuplex = mCandDuplex; mRun = 0; setIrq = 1;
          end
        end else if (mRun > 0) begin
          mRun = 0; mAn = 0;
        end else if (s[1] && !s[0]) begin
          mAn++;
          if (mAn == ANTO) begin
            mRestart = 1; mAn = 0;
          end
        end else begin
          mAn = 0;
        end
      end else if (!good || s[11:10] != mSpeed) begin
        mUp = 0; drop = 1; setIrq = 1;
      end
      if (countClear) mDrops = 0;
      if (drop && mDrops < (1 << CW) - 1) mDrops++;
`ifdef LINK_MONITOR_IRQ_EN
      if (setIrq) mIrq = 1;
      else if (irqAck) mIrq = 0;
`endif
      mPipe2 = mPipe1;
      mPipe1 = status;
      e.linkUp    = mUp;
      e.speed     = mSpeed;
      e.duplex    = mDuplex;
      e.is10100   = (mSpeed != 2'b10);
      e.is100     = (mSpeed == 2'b01);
      e.anRestart = mRestart;
      e.count     = CW'(mDrops);
      e.irq       = mIrq;
      expQ.push_back(e);
    end
  end

  // Monitor: one comparison per clock, sampled 1 ns after the rising edge.
  initial forever begin
    Expect e, a;
    @(posedge clk);
    #1;
    if (!rst) begin
      a.linkUp    = linkUp;
      a.speed     = speed;
      a.duplex    = duplex;
      a.is10100   = is10100;
      a.is100     = is100;
      a.anRestart = anRestart;
      a.count     = dropCount;
`ifdef LINK_MONITOR_IRQ_EN
      a.irq       = irq;
`else
      a.irq       = 1'b0;
`endif
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL scoreboard at %0t: no expected entry, got %h", $time, a);
      end else begin
        e = expQ.pop_front();
        if (a === e) passCount++;
        else $display("[TB] FAIL outputs at %0t: got up=%b spd=%b dup=%b s10100=%b s100=%b anr=%b cnt=%0d irq=%b, want up=%b spd=%b dup=%b s10100=%b s100=%b anr=%b cnt=%0d irq=%b",
                      $time, a.linkUp, a.speed, a.duplex, a.is10100, a.is100, a.anRestart, a.count, a.irq,
                      e.linkUp, e.speed, e.duplex, e.is10100, e.is100, e.anRestart, e.count, e.irq);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
  endtask

  // Drive one status value for a number of cycles, changing inputs on negedges.
  task automatic applyStimulus(input logic [15:0] value, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      status     = value;
      countClear = randomClear ? ($urandom_range(0, 15) == 0) : 1'b0;
`ifdef LINK_MONITOR_IRQ_EN
      irqAck     = randomAck ? ($urandom_range(0, 3) == 0) : 1'b0;
`endif
    end
  endtask

  // Drop the link for one cycle and pulse clear/ack on the edge the FSM sees it.
  task automatic dropWithPulse(input logic doClear, input logic doAck);
    @(negedge clk); status = 16'h1802;
    @(negedge clk); status = 16'h1803;
    @(negedge clk);
    countClear = doClear;
`ifdef LINK_MONITOR_IRQ_EN
    irqAck = doAck;
`else
    if (doAck) countClear = doClear;
`endif
    @(negedge clk);
    countClear = 1'b0;
`ifdef LINK_MONITOR_IRQ_EN
    irqAck = 1'b0;
`endif
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " link_up"}, 32'(linkUp), 0);
    checkOutput({tag, " speed"}, 32'(speed), 2);
    checkOutput({tag, " duplex"}, 32'(duplex), 1);
    checkOutput({tag, " speed_is_10_100"}, 32'(is10100), 0);
    checkOutput({tag, " speed_is_100"}, 32'(is100), 0);
    checkOutput({tag, " an_restart"}, 32'(anRestart), 0);
    checkOutput({tag, " link_drop_count"}, 32'(dropCount), 0);
`ifdef LINK_MONITOR_IRQ_EN
    checkOutput({tag, " irq"}, 32'(irq), 0);
`endif
  endtask

  task automatic measureLatency(input string name);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (linkUp) begin
        lat = i;
        break;
      end
    end
    checkOutput(name, 32'(lat), 11);
  endtask

  logic [15:0] table_[8] = '{16'h1803, 16'h1403, 16'h1003, 16'h0803,
                             16'h1C03, 16'h0002, 16'h0000, 16'hE7F3};

  initial begin
    // Reset state, then 1G full held from the first cycle after release.
    status = 16'h1803;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    measureLatency("1G link_up latency");
    checkOutput("1G speed", 32'(speed), 2);
    checkOutput("1G speed_is_10_100", 32'(is10100), 0);
    checkOutput("1G speed_is_100", 32'(is100), 0);
    applyStimulus(16'h1803, 4);

    // 100M full: speed change drops the link and it requalifies at 100M.
    applyStimulus(16'h1403, 20);
    checkOutput("100M speed", 32'(speed), 1);
    checkOutput("100M speed_is_10_100", 32'(is10100), 1);
    checkOutput("100M speed_is_100", 32'(is100), 1);

    // One-cycle loss of link.
    applyStimulus(16'h1402, 1);
    applyStimulus(16'h1403, 20);
    checkOutput("requalified link_up", 32'(linkUp), 1);
    checkOutput("drop count after blip", 32'(dropCount), 2);

    // Speed change part way through qualification.
    applyStimulus(16'h0000, 3);
    applyStimulus(16'h1803, 7);
    applyStimulus(16'h1403, 20);

    // Sync without link: periodic autonegotiation restarts.
    applyStimulus(16'h0002, 80);

    // Saturation of the drop counter.
    applyStimulus(16'h1803, 14);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h1802, 1);
      applyStimulus(16'h1803, 14);
    end
    checkOutput("saturated count", 32'(dropCount), 15);

    // Clear coincident with a drop.
    dropWithPulse(1'b1, 1'b0);
    applyStimulus(16'h1803, 14);
    checkOutput("clear with drop", 32'(dropCount), 1);

`ifdef LINK_MONITOR_IRQ_EN
    checkOutput("irq after up", 32'(irq), 1);
    dropWithPulse(1'b0, 1'b1);
    checkOutput("irq set beats ack", 32'(irq), 1);
    applyStimulus(16'h1803, 14);
    @(negedge clk); irqAck = 1'b1;
    @(negedge clk); irqAck = 1'b0;
    checkOutput("irq cleared by ack", 32'(irq), 0);
`endif

    // Asynchronous reset while qualifying.
    applyStimulus(16'h0000, 3);
    applyStimulus(16'h1803, 6);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkResetState("async reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    measureLatency("post-reset link_up latency");

    // Randomised traffic.
    randomClear = 1'b1;
    randomAck   = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = (($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 1));
      applyStimulus(table_[sel], $urandom_range(1, 24));
    end
    randomClear = 1'b0;
    randomAck   = 1'b0;
    applyStimulus(16'h1803, 4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
